// File: rtl/mrd_fsmsource_p4.sv
// Read side of the 4-parallel mrd path: fetches a frame from 7 interleaved banks
// (sample k in bank k%7, address k/7) and streams it 4 samples per beat behind a credit-limited FIFO.
module mrd_fsmsource_p4 #(
    parameter int wADDR      = 8,
    parameter int wDATA      = 16,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [11:0]      len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             rden      [0:6],
    output logic [wADDR-1:0] rdaddr    [0:6],
    input  logic [wDATA-1:0] dout_real [0:6],
    input  logic [wDATA-1:0] dout_imag [0:6],
    output logic             out_valid,
    input  logic             out_ready,
    output logic [wDATA-1:0] out_real  [0:3],
    output logic [wDATA-1:0] out_imag  [0:3],
    output logic             out_sop,
    output logic             out_eop,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RD    = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
    localparam logic [13:0] MAX_SAMPLES = 14'(7 * (2 ** wADDR));

    typedef struct packed {
        logic                  vld;
        logic                  sop;
        logic                  eop;
        logic [3:0][2:0]       bank;
    } pipe_t;

    typedef struct packed {
        logic [3:0][wDATA-1:0] re;
        logic [3:0][wDATA-1:0] im;
        logic                  sop;
        logic                  eop;
    } beat_t;

    state_t                 state_q, state_d;
    logic [9:0]             nbeats_q, nbeats_d;
    logic [9:0]             iss_cnt_q, iss_cnt_d;
    logic [3:0][2:0]        bank_idx_q, bank_idx_d;
    logic [3:0][wADDR-1:0]  bank_addr_q, bank_addr_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [CW-1:0]          inflight_q, inflight_d;
    logic [CW-1:0]          count_q, count_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    pipe_t                  pipe_q [RD_LAT];
    pipe_t                  pipe_d [RD_LAT];
    beat_t                  fifo_q [FIFO_DEPTH];
    beat_t                  fifo_d [FIFO_DEPTH];

    logic [9:0]             len_beats;
    logic                   len_ok;
    logic                   unused_len;
    logic                   pop;
    logic                   issue;
    logic                   last_beat;
    pipe_t                  ret_e;
    beat_t                  head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign len_beats  = len[11:2];
    assign unused_len = ^len[1:0];
    assign len_ok     = (len_beats != 10'd0) && ({2'b00, len_beats, 2'b00} <= MAX_SAMPLES);

    assign head      = fifo_q[rd_ptr_q];
    assign ret_e     = pipe_q[RD_LAT-1];
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign last_beat = (iss_cnt_q == nbeats_q - 10'd1);

    // Credit counts reads still in the RAM pipe plus beats parked in the FIFO; a same-cycle pop frees a slot.
    assign issue = (state_q == S_RD) &&
                   ((inflight_q + count_q - CW'(pop)) < CW'(FIFO_DEPTH));

    always_comb begin
        state_d     = state_q;
        nbeats_d    = nbeats_q;
        iss_cnt_d   = iss_cnt_q;
        bank_idx_d  = bank_idx_q;
        bank_addr_d = bank_addr_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        state_d   = S_RD;
                        nbeats_d  = len_beats;
                        iss_cnt_d = '0;
                        for (int j = 0; j < 4; j++) begin
                            bank_idx_d[j]  = 3'(j);
                            bank_addr_d[j] = '0;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RD: begin
                if (issue) begin
                    iss_cnt_d = iss_cnt_q + 10'd1;
                    // Advancing 4 samples moves a lane +4 banks, wrapping to the next address after bank 6.
                    for (int j = 0; j < 4; j++) begin
                        if (bank_idx_q[j] <= 3'd2) begin
                            bank_idx_d[j] = bank_idx_q[j] + 3'd4;
                        end else begin
                            bank_idx_d[j]  = bank_idx_q[j] - 3'd3;
                            bank_addr_d[j] = bank_addr_q[j] + wADDR'(1);
                        end
                    end
                    if (last_beat) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && head.eop) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        for (int b = 0; b < 7; b++) begin
            rden[b]   = 1'b0;
            rdaddr[b] = '0;
        end
        if (issue) begin
            for (int j = 0; j < 4; j++) begin
                rden[bank_idx_q[j]]   = 1'b1;
                rdaddr[bank_idx_q[j]] = bank_addr_q[j];
            end
        end
    end

    always_comb begin
        pipe_d          = pipe_q;
        pipe_d[0].vld   = issue;
        pipe_d[0].sop   = (iss_cnt_q == 10'd0);
        pipe_d[0].eop   = last_beat;
        pipe_d[0].bank  = bank_idx_q;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        inflight_d = inflight_q + CW'(issue) - CW'(ret_e.vld);
        count_d    = count_q + CW'(ret_e.vld) - CW'(pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_d     = fifo_q;
        if (ret_e.vld) begin
            for (int j = 0; j < 4; j++) begin
                fifo_d[wr_ptr_q].re[j] = dout_real[ret_e.bank[j]];
                fifo_d[wr_ptr_q].im[j] = dout_imag[ret_e.bank[j]];
            end
            fifo_d[wr_ptr_q].sop = ret_e.sop;
            fifo_d[wr_ptr_q].eop = ret_e.eop;
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            out_real[j] = out_valid ? head.re[j] : '0;
            out_imag[j] = out_valid ? head.im[j] : '0;
        end
        out_sop = out_valid && head.sop;
        out_eop = out_valid && head.eop;
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            nbeats_q    <= '0;
            iss_cnt_q   <= '0;
            bank_idx_q  <= '0;
            bank_addr_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            inflight_q  <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            nbeats_q    <= nbeats_d;
            iss_cnt_q   <= iss_cnt_d;
            bank_idx_q  <= bank_idx_d;
            bank_addr_q <= bank_addr_d;
            done_q      <= done_d;
            err_q       <= err_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pipe_q      <= pipe_d;
        end
    end

    // Beat storage needs no reset: it is only visible through count_q, which is reset.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

endmodule

// File: tb/tb_mrd_fsmsource_p4.sv
// Bench for mrd_fsmsource_p4: 7-bank RAM model with RD_LAT pipeline, scoreboard of expected beats,
// bank/address model for every issued read, and timing checks on start/done/err.
module tb_mrd_fsmsource_p4;

    localparam int wADDR      = 8;
    localparam int wDATA      = 16;
    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int BW         = 8 * wDATA + 2;
    localparam int AW         = 7 * wADDR;
    localparam int DEPTH      = 1 << wADDR;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [11:0]      len;
    logic             busy;
    logic             done;
    logic             err;
    logic             rden      [0:6];
    logic [wADDR-1:0] rdaddr    [0:6];
    logic [wDATA-1:0] dout_real [0:6];
    logic [wDATA-1:0] dout_imag [0:6];
    logic             out_valid;
    logic             out_ready;
    logic [wDATA-1:0] out_real  [0:3];
    logic [wDATA-1:0] out_imag  [0:3];
    logic             out_sop;
    logic             out_eop;
    logic [1:0]       dbg_state;

    mrd_fsmsource_p4 #(
        .wADDR(wADDR), .wDATA(wDATA), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .busy(busy), .done(done), .err(err),
        .rden(rden), .rdaddr(rdaddr), .dout_real(dout_real), .dout_imag(dout_imag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_imag(out_imag),
        .out_sop(out_sop), .out_eop(out_eop), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- RAM model ----------------
    logic [wDATA-1:0] mem_re [0:6][0:DEPTH-1];
    logic [wDATA-1:0] mem_im [0:6][0:DEPTH-1];
    logic [wDATA-1:0] pr_re  [0:6][0:RD_LAT-1];
    logic [wDATA-1:0] pr_im  [0:6][0:RD_LAT-1];

    always @(posedge clk) begin
        for (int b = 0; b < 7; b++) begin
            pr_re[b][0] <= rden[b] ? mem_re[b][rdaddr[b]] : 16'hdead;
            pr_im[b][0] <= rden[b] ? mem_im[b][rdaddr[b]] : 16'hbeef;
            for (int s = 1; s < RD_LAT; s++) begin
                pr_re[b][s] <= pr_re[b][s-1];
                pr_im[b][s] <= pr_im[b][s-1];
            end
        end
    end

    always_comb begin
        for (int b = 0; b < 7; b++) begin
            dout_real[b] = pr_re[b][RD_LAT-1];
            dout_imag[b] = pr_im[b][RD_LAT-1];
        end
    end

    // ---------------- scoreboard state ----------------
    logic [BW-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int gen = 0;
    int ready_mode = 0;
    int iss_seen, popped, done_cnt, err_cnt, idle_rden_cnt, max_out;
    int fv_cyc, done_cyc, cur_len, t_start;
    bit fv_seen, prev_hold;
    logic [BW-1:0] prev_beat;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [wDATA-1:0] smp_re(input int k, input int g);
        return wDATA'(k + g * 4096);
    endfunction

    function automatic logic [BW-1:0] exp_beat(input int b, input int nb, input int g);
        logic [BW-1:0] v;
        v = '0;
        for (int j = 0; j < 4; j++) begin
            v[j*wDATA +: wDATA]     = smp_re(4*b + j, g);
            v[(4+j)*wDATA +: wDATA] = ~smp_re(4*b + j, g);
        end
        v[8*wDATA]     = (b == nb - 1);
        v[8*wDATA + 1] = (b == 0);
        return v;
    endfunction

    function automatic logic [BW-1:0] out_vec();
        logic [BW-1:0] v;
        v = '0;
        for (int j = 0; j < 4; j++) begin
            v[j*wDATA +: wDATA]     = out_real[j];
            v[(4+j)*wDATA +: wDATA] = out_imag[j];
        end
        v[8*wDATA]     = out_eop;
        v[8*wDATA + 1] = out_sop;
        return v;
    endfunction

    function automatic logic [6:0] rden_vec();
        logic [6:0] v;
        for (int b = 0; b < 7; b++) v[b] = rden[b];
        return v;
    endfunction

    function automatic logic [AW-1:0] addr_vec();
        logic [AW-1:0] v;
        for (int b = 0; b < 7; b++) v[b*wADDR +: wADDR] = rdaddr[b];
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic preload(input int g);
        for (int k = 0; k < 7 * DEPTH; k++) begin
            mem_re[k % 7][k / 7] = smp_re(k, g);
            mem_im[k % 7][k / 7] = ~smp_re(k, g);
        end
    endtask

    task automatic clear_frame();
        iss_seen = 0;
        popped   = 0;
        fv_seen  = 1'b0;
    endtask

    task automatic start_frame(input logic [11:0] l);
        int nb;
        nb = int'(l[11:2]);
        @(posedge clk); #1;
        clear_frame();
        cur_len = int'(l);
        t_start = cyc;
        if (nb >= 1 && nb * 4 <= 7 * DEPTH) begin
            for (int b = 0; b < nb; b++) exp_q.push_back(exp_beat(b, nb, gen));
        end
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n0;
        int c;
        n0 = done_cnt;
        c  = 0;
        while (done_cnt == n0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        chk(tag, 256'(done_cnt - n0), 256'(1));
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [6:0]    rv, ev;
        logic [AW-1:0] ea;
        logic [BW-1:0] cur;
        int k;
        iss_seen = 0; popped = 0; done_cnt = 0; err_cnt = 0; idle_rden_cnt = 0;
        max_out = 0; fv_seen = 1'b0; prev_hold = 1'b0; prev_beat = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                rv = rden_vec();
                if (rv != 7'd0) begin
                    if (!busy) idle_rden_cnt++;
                    ev = '0;
                    ea = '0;
                    for (int j = 0; j < 4; j++) begin
                        k = 4 * iss_seen + j;
                        ev[k % 7] = 1'b1;
                        ea[(k % 7)*wADDR +: wADDR] = wADDR'(k / 7);
                    end
                    chk($sformatf("rden_banks%0d", iss_seen), 256'(rv), 256'(ev));
                    chk($sformatf("rden_addr%0d", iss_seen), 256'(addr_vec()), 256'(ea));
                    if (cur_len == 16 && iss_seen == 3) begin
                        chk("map16_beat3_banks", 256'(rv), 256'(7'b1100011));
                        chk("map16_beat3_addr", 256'({rdaddr[6], rdaddr[5], rdaddr[1], rdaddr[0]}),
                            256'({8'd1, 8'd1, 8'd2, 8'd2}));
                    end
                    iss_seen++;
                end
                cur = out_vec();
                if (prev_hold) begin
                    chk("hold_valid", 256'(out_valid), 256'(1'b1));
                    chk("hold_data", 256'(cur), 256'(prev_beat));
                end
                if (out_valid && !fv_seen) begin
                    fv_seen = 1'b1;
                    fv_cyc  = cyc;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) chk("sb_has_entry", 256'(exp_q.size()), 256'(1));
                    else chk($sformatf("beat%0d", popped), 256'(cur), 256'(exp_q.pop_front()));
                    popped++;
                end
                if (iss_seen - popped > max_out) max_out = iss_seen - popped;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (err) err_cnt++;
                prev_hold = out_valid && !out_ready;
                prev_beat = cur;
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int d0, e0, c;
        rst = 1'b1; start = 1'b0; len = '0; cur_len = 0; t_start = 0;
        preload(0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ctrl", 256'({busy, done, err, out_valid, out_sop, out_eop}), 256'(0));
        chk("reset_rden", 256'(rden_vec()), 256'(0));
        chk("reset_addr", 256'(addr_vec()), 256'(0));
        chk("reset_data", 256'(out_vec()), 256'(0));
        chk("reset_state", 256'(dbg_state), 256'(0));

        // len=28, ready held high: latency and throughput
        start_frame(12'd28);
        @(negedge clk);
        chk("t28_busy", 256'(busy), 256'(1));
        wait_done("t28_done", 200);
        chk("t28_first_valid", 256'(fv_cyc - t_start), 256'(RD_LAT + 2));
        chk("t28_done_time", 256'(done_cyc - t_start), 256'(RD_LAT + 7 + 2));
        chk("t28_beats", 256'(popped), 256'(7));
        chk("t28_issued", 256'(iss_seen), 256'(7));
        chk("t28_sb_empty", 256'(exp_q.size()), 256'(0));
        @(negedge clk);
        chk("t28_idle", 256'(busy), 256'(0));

        // len=16: bank mapping of beat 3
        start_frame(12'd16);
        wait_done("t16_done", 200);
        chk("t16_beats", 256'(popped), 256'(4));

        // rejected lengths
        e0 = err_cnt;
        start_frame(12'd2);
        @(negedge clk);
        chk("err2_pulse", 256'(err), 256'(1));
        chk("err2_busy", 256'(busy), 256'(0));
        @(negedge clk);
        chk("err2_single", 256'(err), 256'(0));
        start_frame(12'd1800);
        @(negedge clk);
        chk("err1800_pulse", 256'(err), 256'(1));
        chk("err1800_busy", 256'(busy), 256'(0));
        @(negedge clk);
        chk("err1800_single", 256'(err), 256'(0));
        repeat (4) @(posedge clk);
        chk("err_no_rden", 256'(iss_seen), 256'(0));
        chk("err_count", 256'(err_cnt - e0), 256'(2));

        // start re-pulsed while a frame is running
        e0 = err_cnt;
        d0 = done_cnt;
        start_frame(12'd28);
        repeat (3) @(posedge clk);
        #1 start = 1'b1; len = 12'd8;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("restart_done", 200);
        repeat (6) @(posedge clk);
        chk("restart_single_done", 256'(done_cnt - d0), 256'(1));
        chk("restart_no_err", 256'(err_cnt - e0), 256'(0));
        chk("restart_beats", 256'(popped), 256'(7));
        chk("restart_sb_empty", 256'(exp_q.size()), 256'(0));

        // max frame with random backpressure
        ready_mode = 1;
        max_out = 0;
        start_frame(12'd1792);
        wait_done("max_done", 6000);
        chk("max_beats", 256'(popped), 256'(448));
        chk("max_issued", 256'(iss_seen), 256'(448));
        chk("max_sb_empty", 256'(exp_q.size()), 256'(0));
        chk("max_outstanding_le_depth", 256'(max_out <= FIFO_DEPTH), 256'(1));
        ready_mode = 0;
        repeat (3) @(posedge clk);

        // reset in the middle of a len=64 frame
        start_frame(12'd64);
        c = 0;
        while (popped < 3 && c < 200) begin
            @(posedge clk);
            c++;
        end
        chk("rst_reach_beat3", 256'(popped >= 3), 256'(1));
        #1 rst = 1'b1;
        d0 = done_cnt;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        clear_frame();
        @(negedge clk);
        chk("rstmid_ctrl", 256'({busy, done, err, out_valid, out_sop, out_eop}), 256'(0));
        chk("rstmid_rden", 256'(rden_vec()), 256'(0));
        chk("rstmid_addr", 256'(addr_vec()), 256'(0));
        chk("rstmid_data", 256'(out_vec()), 256'(0));
        chk("rstmid_state", 256'(dbg_state), 256'(0));
        repeat (8) @(posedge clk);
        chk("rstmid_no_done", 256'(done_cnt - d0), 256'(0));
        chk("rstmid_no_stale", 256'(popped), 256'(0));
        gen = 1;
        preload(1);
        start_frame(12'd8);
        wait_done("after_rst_done", 200);
        repeat (4) @(posedge clk);
        chk("after_rst_beats", 256'(popped), 256'(2));
        chk("after_rst_issued", 256'(iss_seen), 256'(2));
        chk("after_rst_sb_empty", 256'(exp_q.size()), 256'(0));

        chk("idle_rden", 256'(idle_rden_cnt), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
